// File: rtl/i2c_gain_target_if.sv
// Pad and gain-bank signals of the I2C gain target.
// The slave side is the target itself; master is the pad/bank environment.
interface i2c_gain_target_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_data, reg_we, busy
    );

    modport master (
        output scl, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_data, reg_we, busy
    );
endinterface

// File: rtl/i2c_gain_target.sv
// I2C target turning controller writes into gain-bank write strobes,
// with sequential reads of the same bank; SDA is open drain.
module i2c_gain_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A,
    parameter logic [7:0] REG_BASE   = 8'h01,
    parameter int         NUM_REGS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    i2c_gain_target_if.slave bus
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    localparam logic [8:0] REG_END = {1'b0, REG_BASE} + 9'(NUM_REGS);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    logic [3:0] state;
    logic [3:0] cnt;
    logic [7:0] shift;
    logic       rw;
    logic       ack_ok;
    logic       in_range;
    logic [7:0] rd_byte;

    // Sync flops idle high so reset release never fakes a START/STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign in_range = (bus.reg_addr >= REG_BASE)
                   && ({1'b0, bus.reg_addr} < REG_END);
    assign rd_byte  = in_range ? bus.reg_rdata : 8'hFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            shift        <= 8'h00;
            rw           <= 1'b0;
            ack_ok       <= 1'b0;
            bus.sda_oe   <= 1'b0;
            bus.reg_addr <= 8'h00;
            bus.reg_data <= 8'h00;
            bus.reg_we   <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.reg_we <= 1'b0;
            // Pointer advances the clk after the strobe so the bank sees
            // the written address alongside reg_we
            if (bus.reg_we)
                bus.reg_addr <= bus.reg_addr + 8'd1;

            if (start_det) begin
                state      <= S_ADDR;
                cnt        <= 4'd0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (stop_det) begin
                state      <= S_IDLE;
                cnt        <= 4'd0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (scl_rise) begin
                if (state == S_ADDR || state == S_PTR || state == S_WDATA) begin
                    shift <= {shift[6:0], sda_s};
                    cnt   <= cnt + 4'd1;
                end else if (state == S_RDATA_ACK) begin
                    // Advance on ACK now so reg_rdata is settled by the fall
                    ack_ok <= ~sda_s;
                    if (!sda_s)
                        bus.reg_addr <= bus.reg_addr + 8'd1;
                end
            end else if (scl_fall) begin
                unique case (state)
                    S_ADDR: begin
                        if (cnt == 4'd8) begin
                            cnt <= 4'd0;
                            if (shift[7:1] == SLAVE_ADDR) begin
                                rw         <= shift[0];
                                bus.sda_oe <= 1'b1;
                                bus.busy   <= 1'b1;
                                state      <= S_ADDR_ACK;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK, S_RDATA_ACK: begin
                        if ((state == S_ADDR_ACK && rw)
                            || (state == S_RDATA_ACK && ack_ok)) begin
                            // First read bit goes out on the fall ending the ACK
                            shift      <= {rd_byte[6:0], 1'b0};
                            bus.sda_oe <= ~rd_byte[7];
                            cnt        <= 4'd1;
                            state      <= S_RDATA;
                        end else if (state == S_ADDR_ACK) begin
                            bus.sda_oe <= 1'b0;
                            state      <= S_PTR;
                        end else begin
                            bus.sda_oe <= 1'b0;
                            bus.busy   <= 1'b0;
                            state      <= S_IGNORE;
                        end
                    end
                    S_PTR: begin
                        if (cnt == 4'd8) begin
                            cnt          <= 4'd0;
                            bus.reg_addr <= shift;
                            bus.sda_oe   <= 1'b1;
                            state        <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        bus.sda_oe <= 1'b0;
                        state      <= S_WDATA;
                    end
                    S_WDATA: begin
                        if (cnt == 4'd8) begin
                            cnt <= 4'd0;
                            if (in_range) begin
                                bus.reg_data <= shift;
                                bus.reg_we   <= 1'b1;
                                bus.sda_oe   <= 1'b1;
                                state        <= S_WDATA_ACK;
                            end else begin
                                bus.busy <= 1'b0;
                                state    <= S_IGNORE;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (cnt == 4'd8) begin
                            cnt        <= 4'd0;
                            bus.sda_oe <= 1'b0;
                            state      <= S_RDATA_ACK;
                        end else begin
                            bus.sda_oe <= ~shift[7];
                            shift      <= {shift[6:0], 1'b0};
                            cnt        <= cnt + 4'd1;
                        end
                    end
                    default: bus.sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_gain_target.sv
// Directed bench for i2c_gain_target: controller model on an open-drain
// bus plus a bank model returning reg_addr + 0x10.
module tb_i2c_gain_target;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];

    always #10 clk = ~clk;

    i2c_gain_target_if bus();

    assign bus.scl       = scl;
    assign bus.sda_in    = m_sda & ~bus.sda_oe;
    assign bus.reg_rdata = bus.reg_addr + 8'h10;

    i2c_gain_target dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.reg_we) begin
            wa.push_back(bus.reg_addr);
            wd.push_back(bus.reg_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic b, output logic s);
        #60 m_sda = b;
        #60 scl = 1'b1;
        #50 s = bus.sda_in;
        #50 scl = 1'b0;
    endtask

    task automatic i2c_start();
        #60 m_sda = 1'b1;
        #60 scl = 1'b1;
        #100 m_sda = 1'b0;
        #100 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #60 m_sda = 1'b0;
        #60 scl = 1'b1;
        #100 m_sda = 1'b1;
        #100;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] r);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            r[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] r;
        int         n0;

        #5;
        #100 rst_n = 1'b1;
        #100;
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_reg_addr", bus.reg_addr, 8'h00);
        check("rst_reg_data", bus.reg_data, 8'h00);
        check("rst_reg_we", bus.reg_we, 0);
        check("rst_busy", bus.busy, 0);

        // 1: ten sequential writes from pointer 0x01
        n0 = wa.size();
        i2c_start();
        wbyte(8'hD4, ack);
        check("t1_addr_ack", ack, 0);
        check("t1_busy", bus.busy, 1);
        wbyte(8'h01, ack);
        check("t1_ptr_ack", ack, 0);
        for (int i = 0; i < 10; i++) begin
            wbyte(8'(17 + i), ack);
            check("t1_data_ack", ack, 0);
        end
        i2c_stop();
        check("t1_busy_after_stop", bus.busy, 0);
        check("t1_we_count", wa.size() - n0, 10);
        for (int i = 0; i < 10; i++) begin
            check("t1_we_addr", wa[n0 + i], 8'(1 + i));
            check("t1_we_data", wd[n0 + i], 8'(17 + i));
        end
        check("t1_ptr_final", bus.reg_addr, 8'h0B);

        // 2: foreign address is never acknowledged
        n0 = wa.size();
        i2c_start();
        wbyte(8'hA0, ack);
        check("t2_addr_nack", ack, 1);
        check("t2_busy", bus.busy, 0);
        wbyte(8'h01, ack);
        check("t2_b1_nack", ack, 1);
        wbyte(8'h55, ack);
        check("t2_b2_nack", ack, 1);
        check("t2_busy_end", bus.busy, 0);
        i2c_stop();
        check("t2_no_we", wa.size() - n0, 0);

        // 3: last valid register, then pointer runs out of range
        n0 = wa.size();
        i2c_start();
        wbyte(8'hD4, ack);
        check("t3_addr_ack", ack, 0);
        wbyte(8'h0A, ack);
        check("t3_ptr_ack", ack, 0);
        wbyte(8'h11, ack);
        check("t3_d0_ack", ack, 0);
        wbyte(8'h22, ack);
        check("t3_d1_nack", ack, 1);
        check("t3_busy_nack_exit", bus.busy, 0);
        wbyte(8'h33, ack);
        check("t3_ignore_nack", ack, 1);
        i2c_stop();
        check("t3_we_count", wa.size() - n0, 1);
        check("t3_we_addr", wa[n0], 8'h0A);
        check("t3_we_data", wd[n0], 8'h11);
        check("t3_reg_data_held", bus.reg_data, 8'h11);

        // 4: pointer write, repeated START, two-byte read
        n0 = wa.size();
        i2c_start();
        wbyte(8'hD4, ack);
        check("t4_addr_ack", ack, 0);
        wbyte(8'h03, ack);
        check("t4_ptr_ack", ack, 0);
        i2c_start();
        wbyte(8'hD5, ack);
        check("t4_raddr_ack", ack, 0);
        rbyte(1'b0, r);
        check("t4_rd0", r, 8'h13);
        rbyte(1'b1, r);
        check("t4_rd1", r, 8'h14);
        i2c_stop();
        check("t4_no_we", wa.size() - n0, 0);
        check("t4_sda_released", bus.sda_oe, 0);

        // 5: reset during the 4th bit of a data byte
        n0 = wa.size();
        i2c_start();
        wbyte(8'hD4, ack);
        wbyte(8'h02, ack);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        #60 m_sda = 1'b1;
        #60 scl = 1'b1;
        #50 rst_n = 1'b0;
        #2;
        check("t5_sda_oe_rst", bus.sda_oe, 0);
        check("t5_busy_rst", bus.busy, 0);
        check("t5_reg_data_rst", bus.reg_data, 8'h00);
        #48 scl = 1'b0;
        #40 rst_n = 1'b1;
        i2c_stop();
        check("t5_no_we", wa.size() - n0, 0);
        i2c_start();
        wbyte(8'hD4, ack);
        check("t5_addr_ack", ack, 0);
        wbyte(8'h02, ack);
        check("t5_ptr_ack", ack, 0);
        wbyte(8'h5A, ack);
        check("t5_data_ack", ack, 0);
        i2c_stop();
        check("t5_we_count", wa.size() - n0, 1);
        check("t5_we_addr", wa[n0], 8'h02);
        check("t5_we_data", wd[n0], 8'h5A);

        // 6: pointer-only write, STOP, then a fresh read
        n0 = wa.size();
        i2c_start();
        wbyte(8'hD4, ack);
        wbyte(8'h05, ack);
        check("t6_ptr_ack", ack, 0);
        i2c_stop();
        check("t6_ptr_set", bus.reg_addr, 8'h05);
        i2c_start();
        wbyte(8'hD5, ack);
        check("t6_raddr_ack", ack, 0);
        rbyte(1'b1, r);
        check("t6_rd", r, 8'h15);
        i2c_stop();
        check("t6_no_we", wa.size() - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
